// File: rtl/spine_pkg.sv
// rtl/spine_pkg.sv - flit field layout and destination helpers for the spine switch
package spine_pkg;
  localparam int DWIDTH   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 10;
  localparam int ADDR_W   = 6;

  // Destination GPU address shifted down so the caller can slice the port-select bits at bit 0.
  function automatic logic [ADDR_W-1:0] port_of(input logic [DWIDTH-1:0] flit, input int sel_lsb);
    logic [ADDR_W-1:0] dest;
    dest = flit[ADDR_MSB:ADDR_LSB];
    return dest >> sel_lsb;
  endfunction
endpackage

// File: rtl/spine_rr_arbiter.sv
// rtl/spine_rr_arbiter.sv - per-output round-robin arbiter with registered priority pointer
module spine_rr_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  // Scan from ptr upward; PW-bit index wraps naturally because N is a power of two.
  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + PW'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= win + 1'b1;
    end
  end
endmodule

// File: rtl/spine_switch.sv
// rtl/spine_switch.sv - spine plane crossbar: buffered leaf inputs, RR-arbitrated registered leaf outputs
module spine_switch #(
  parameter int NUM_PORTS    = 16,
  parameter int DWIDTH       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PORT_SEL_LSB = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arb_enable,
  input  logic [NUM_PORTS*DWIDTH-1:0]    leaf_in_data,
  input  logic [NUM_PORTS-1:0]           leaf_in_valid,
  output logic [NUM_PORTS*DWIDTH-1:0]    leaf_out_data,
  output logic [NUM_PORTS-1:0]           leaf_out_valid,
  output logic [NUM_PORTS*6-1:0]         leaf_out_dest_addr,
  output logic [NUM_PORTS-1:0]           drop_pulse,
  output logic [NUM_PORTS-1:0]           fifo_full,
  output logic [15:0]                    drop_count
);
  import spine_pkg::*;

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_PORTS-1:0] empty, full, pop, push, drop;
  logic [DWIDTH-1:0]    head      [NUM_PORTS];
  logic [PW-1:0]        head_port [NUM_PORTS];
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt       [NUM_PORTS];
  logic [DWIDTH-1:0]    sel_data  [NUM_PORTS];
  logic [DWIDTH-1:0]    out_data  [NUM_PORTS];
  logic [16:0]          drop_add;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;

    assign head[i]      = mem[rd_ptr[AW-1:0]];
    assign empty[i]     = (wr_ptr == rd_ptr);
    assign full[i]      = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
    assign head_port[i] = PW'(port_of(head[i], PORT_SEL_LSB));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push[i]      = leaf_in_valid[i] & (~full[i] | pop[i]);
    assign drop[i]      = leaf_in_valid[i] & full[i] & ~pop[i];

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr[AW-1:0]] <= leaf_in_data[i*DWIDTH +: DWIDTH];
          wr_ptr              <= wr_ptr + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = arb_enable & ~empty[i] & (head_port[i] == PW'(o));
      end
    end
  end

  // Each input requests one output only, so OR-ing grants yields at most one pop per FIFO.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      sel_data[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pop[i]      = pop[i] | gnt[o][i];
        sel_data[o] = sel_data[o] | (gnt[o][i] ? head[i] : '0);
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    spine_rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[o]),
      .grant (gnt[o])
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        leaf_out_valid[o] <= 1'b0;
        out_data[o]       <= '0;
      end else if (|gnt[o]) begin
        leaf_out_valid[o] <= 1'b1;
        out_data[o]       <= sel_data[o];
      end else begin
        leaf_out_valid[o] <= 1'b0;
      end
    end

    assign leaf_out_data[o*DWIDTH +: DWIDTH] = out_data[o];
    assign leaf_out_dest_addr[o*6 +: 6]      = out_data[o][ADDR_MSB:ADDR_LSB];
  end

  always_comb begin
    drop_add = {1'b0, drop_count};
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop_add = drop_add + {16'd0, drop[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse <= '0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      drop_count <= drop_add[16] ? 16'hFFFF : drop_add[15:0];
    end
  end

  assign fifo_full = full;
endmodule

// File: tb/tb_spine_switch.sv
// tb/tb_spine_switch.sv - directed self-checking bench for spine_switch
module tb_spine_switch;
  logic         clk = 1'b0;
  logic         reset;
  logic         arb_enable;
  logic [255:0] leaf_in_data;
  logic [15:0]  leaf_in_valid;
  logic [255:0] leaf_out_data;
  logic [15:0]  leaf_out_valid;
  logic [95:0]  leaf_out_dest_addr;
  logic [15:0]  drop_pulse;
  logic [15:0]  fifo_full;
  logic [15:0]  drop_count;

  int tests_run    = 0;
  int tests_failed = 0;

  spine_switch #(
    .NUM_PORTS(16), .DWIDTH(16), .FIFO_DEPTH(4), .PORT_SEL_LSB(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .arb_enable         (arb_enable),
    .leaf_in_data       (leaf_in_data),
    .leaf_in_valid      (leaf_in_valid),
    .leaf_out_data      (leaf_out_data),
    .leaf_out_valid     (leaf_out_valid),
    .leaf_out_dest_addr (leaf_out_dest_addr),
    .drop_pulse         (drop_pulse),
    .fifo_full          (fifo_full),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arb_enable = 1'b1; leaf_in_data = '0; leaf_in_valid = '0;
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if (leaf_out_valid !== 16'h0) begin tests_failed++; $display("FAIL reset_valid got %h exp 0", leaf_out_valid); end
    tests_run++;
    if (leaf_out_data !== 256'h0) begin tests_failed++; $display("FAIL reset_data got %h exp 0", leaf_out_data); end
    tests_run++;
    if (drop_count !== 16'h0 || fifo_full !== 16'h0 || drop_pulse !== 16'h0) begin
      tests_failed++; $display("FAIL reset_status got cnt=%h full=%h pulse=%h exp 0", drop_count, fifo_full, drop_pulse);
    end
  endtask

  task automatic test_single();
    leaf_in_data[3*16 +: 16] = 16'h7000; leaf_in_valid = 16'h0008;
    tick();
    leaf_in_valid = '0;
    tests_run++;
    if (leaf_out_valid !== 16'h0) begin tests_failed++; $display("FAIL single_early got %h exp 0", leaf_out_valid); end
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'h0080) begin tests_failed++; $display("FAIL single_valid got %h exp 0080", leaf_out_valid); end
    tests_run++;
    if (leaf_out_data[7*16 +: 16] !== 16'h7000) begin tests_failed++; $display("FAIL single_data got %h exp 7000", leaf_out_data[7*16 +: 16]); end
    tests_run++;
    if (leaf_out_dest_addr[7*6 +: 6] !== 6'd28) begin tests_failed++; $display("FAIL single_dest got %0d exp 28", leaf_out_dest_addr[7*6 +: 6]); end
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'h0) begin tests_failed++; $display("FAIL single_one_cycle got %h exp 0", leaf_out_valid); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0005;
    leaf_in_data[1*16 +: 16] = 16'h0001;
    leaf_in_data[2*16 +: 16] = 16'h0002;
    leaf_in_data[5*16 +: 16] = 16'h0005;
    leaf_in_valid = 16'h0026;
    tick();
    leaf_in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (leaf_out_valid !== 16'h0001 || leaf_out_data[15:0] !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d] got valid=%h data=%h exp valid=0001 data=%h", k, leaf_out_valid, leaf_out_data[15:0], exp_seq[k]);
      end
    end
    tests_run++;
    if (dut.g_out[0].u_arb.ptr !== 4'd6) begin tests_failed++; $display("FAIL rr_ptr0 got %0d exp 6", dut.g_out[0].u_arb.ptr); end
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'h0) begin tests_failed++; $display("FAIL rr_idle got %h exp 0", leaf_out_valid); end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    arb_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      leaf_in_data[4*16 +: 16] = 16'h9000 | 16'(k);
      leaf_in_valid = 16'h0010;
      tick();
      if (drop_pulse[4]) pulses++;
      if (k == 3) begin
        tests_run++;
        if (fifo_full[4] !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got %b exp 1", fifo_full[4]); end
      end
    end
    leaf_in_valid = '0;
    tick();
    if (drop_pulse[4]) pulses++;
    tests_run++;
    if (pulses != 2) begin tests_failed++; $display("FAIL ovf_pulses got %0d exp 2", pulses); end
    tests_run++;
    if (drop_count !== 16'd2) begin tests_failed++; $display("FAIL ovf_count got %0d exp 2", drop_count); end
    tests_run++;
    if (leaf_out_valid !== 16'h0) begin tests_failed++; $display("FAIL ovf_disabled_valid got %h exp 0", leaf_out_valid); end
    arb_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (leaf_out_valid !== 16'h0200 || leaf_out_data[9*16 +: 16] !== (16'h9000 | 16'(k))) begin
        tests_failed++;
        $display("FAIL ovf_drain[%0d] got valid=%h data=%h exp valid=0200 data=%h", k, leaf_out_valid, leaf_out_data[9*16 +: 16], 16'h9000 | 16'(k));
      end
    end
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'h0 || fifo_full[4] !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_after got valid=%h full=%b exp 0 0", leaf_out_valid, fifo_full[4]);
    end
  endtask

  task automatic test_all_ports();
    for (int i = 0; i < 16; i++) leaf_in_data[i*16 +: 16] = (16'(15 - i) << 12) | 16'(i);
    leaf_in_valid = 16'hFFFF;
    tick();
    leaf_in_valid = '0;
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'hFFFF) begin tests_failed++; $display("FAIL all_valid got %h exp ffff", leaf_out_valid); end
    for (int o = 0; o < 16; o++) begin
      tests_run++;
      if (leaf_out_data[o*16 +: 16] !== ((16'(o) << 12) | 16'(15 - o)) || leaf_out_dest_addr[o*6 +: 6] !== 6'(o << 2)) begin
        tests_failed++;
        $display("FAIL all_port[%0d] got data=%h dest=%0d exp data=%h dest=%0d", o, leaf_out_data[o*16 +: 16],
                 leaf_out_dest_addr[o*6 +: 6], (16'(o) << 12) | 16'(15 - o), o << 2);
      end
    end
    tick();
  endtask

  task automatic test_reset_flush();
    arb_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      leaf_in_data[0 +: 16]    = 16'h1000 | 16'(k);
      leaf_in_data[6*16 +: 16] = 16'h2000 | 16'(k);
      leaf_in_valid = 16'h0041;
      tick();
    end
    leaf_in_valid = '0;
    reset = 1'b1;
    tick();
    tests_run++;
    if (leaf_out_valid !== 16'h0 || leaf_out_data !== 256'h0 || drop_count !== 16'h0 ||
        fifo_full !== 16'h0 || drop_pulse !== 16'h0 || leaf_out_dest_addr !== 96'h0) begin
      tests_failed++;
      $display("FAIL flush_reset got valid=%h cnt=%h full=%h pulse=%h exp all 0", leaf_out_valid, drop_count, fifo_full, drop_pulse);
    end
    reset = 1'b0;
    arb_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (leaf_out_valid !== 16'h0 || drop_count !== 16'h0) begin
        tests_failed++; $display("FAIL flush_stale[%0d] got valid=%h cnt=%h exp 0 0", k, leaf_out_valid, drop_count);
      end
    end
  endtask

  task automatic test_saturation();
    arb_enable = 1'b0;
    for (int i = 0; i < 16; i++) leaf_in_data[i*16 +: 16] = 16'h0400 | 16'(i);
    leaf_in_valid = 16'hFFFF;
    repeat (4200) tick();
    tests_run++;
    if (drop_count !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_count got %h exp ffff", drop_count); end
    tests_run++;
    if (drop_pulse !== 16'hFFFF || fifo_full !== 16'hFFFF) begin
      tests_failed++; $display("FAIL sat_status got pulse=%h full=%h exp ffff ffff", drop_pulse, fifo_full);
    end
    repeat (20) tick();
    tests_run++;
    if (drop_count !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold got %h exp ffff", drop_count); end
    leaf_in_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_all_ports();
    test_reset_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
